// File: rtl/somador_subtrator_serial.sv
// rtl/somador_subtrator_serial.sv - bit-serial N-bit adder/subtractor, LSB first
// One full-adder cell plus a carry flip-flop; start/busy/done framed operation.
module somador_subtrator_serial #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         modo,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s,
    output logic         c,
    output logic         ovf,
    output logic         busy,
    output logic         done
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [N-1:0]  r_q;
    logic          modo_q;
    logic          cy_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  s_q;
    logic          c_q;
    logic          ovf_q;
    logic          busy_q;
    logic          done_q;

    logic bb_bit;
    logic sum_bit;
    logic cout;
    logic last_bit;

    // Subtraction inverts B bit by bit; the +1 comes from the carry preset to modo.
    assign bb_bit   = b_q[0] ^ modo_q;
    assign sum_bit  = a_q[0] ^ bb_bit ^ cy_q;
    assign cout     = (a_q[0] & bb_bit) | (a_q[0] & cy_q) | (bb_bit & cy_q);
    assign last_bit = (cnt_q == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            modo_q  <= 1'b0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        modo_q  <= modo;
                        cy_q    <= modo;
                        cnt_q   <= '0;
                        r_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    r_q   <= {sum_bit, r_q[N-1:1]};
                    cy_q  <= cout;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_bit) begin
                        // cy_q here is the carry into the MSB cell.
                        s_q     <= {sum_bit, r_q[N-1:1]};
                        c_q     <= cout;
                        ovf_q   <= cy_q ^ cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s    = s_q;
    assign c    = c_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_somador_subtrator_serial.sv
// tb/tb_somador_subtrator_serial.sv - scoreboard bench for the serial adder/subtractor
`timescale 1ns/1ps
module tb_somador_subtrator_serial;
    localparam int N = 8;

    typedef struct {
        logic [N-1:0] s;
        logic         c;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic         modo;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] s;
    logic         c;
    logic         ovf;
    logic         busy;
    logic         done;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];
    time  tq[$];
    int   busy_run = 0;
    logic prev_done = 1'b0;

    somador_subtrator_serial #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .modo  (modo),
        .a     (a),
        .b     (b),
        .s     (s),
        .c     (c),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv, input logic m);
        logic [N-1:0] bb;
        logic [N:0]   sum;
        exp_t         r;
        bb    = m ? ~bv : bv;
        sum   = {1'b0, av} + {1'b0, bb} + (N+1)'(m);
        r.s   = sum[N-1:0];
        r.c   = sum[N];
        r.ovf = (av[N-1] == bb[N-1]) && (sum[N-1] != av[N-1]);
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        time  t0;
        if (rst) begin
            busy_run  = 0;
            prev_done = 1'b0;
        end else begin
            if (done === 1'b1) begin
                check("done_width", {31'd0, prev_done}, 32'd0);
                if (q.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    e  = q.pop_front();
                    t0 = tq.pop_front();
                    check("s", {24'd0, s}, {24'd0, e.s});
                    check("c", {31'd0, c}, {31'd0, e.c});
                    check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                    check("latency", 32'($time - t0), 32'(N * 10 + 5));
                    check("busy_cycles", 32'(busy_run), 32'(N));
                end
                busy_run = 0;
            end else if (busy === 1'b1) begin
                busy_run++;
            end
            prev_done = (done === 1'b1);
        end
    end

    task automatic start_op(input logic [N-1:0] ai, input logic [N-1:0] bi, input logic mi);
        @(negedge clk);
        a     = ai;
        b     = bi;
        modo  = mi;
        start = 1'b1;
        @(posedge clk);
        q.push_back(model(ai, bi, mi));
        tq.push_back($time);
        #1;
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
        modo  = 1'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) return;
        end
        check("timeout_done", 32'd0, 32'd1);
    endtask

    logic [N-1:0] op_a [6] = '{8'h3C, 8'hFF, 8'h7F, 8'h05, 8'h80, 8'h10};
    logic [N-1:0] op_b [6] = '{8'h05, 8'h01, 8'h01, 8'h07, 8'h01, 8'h10};
    logic         op_m [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        modo  = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
        @(posedge clk);
        @(negedge clk);
        check("rst_s", {24'd0, s}, 32'd0);
        check("rst_c", {31'd0, c}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        a = N'($urandom);
        b = N'($urandom);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;

        for (int i = 0; i < 6; i++) begin
            start_op(op_a[i], op_b[i], op_m[i]);
            wait_done();
        end

        // start held and operands changed during CALC
        @(negedge clk);
        a     = 8'h12;
        b     = 8'h34;
        modo  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        q.push_back(model(8'h12, 8'h34, 1'b0));
        tq.push_back($time);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (done === 1'b1) seen = 1'b1;
                else begin
                    a    = 8'hAA;
                    modo = 1'b1;
                end
            end
            if (!seen) check("timeout_hold", 32'd0, 32'd1);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("no_reaccept_busy", {31'd0, busy}, 32'd0);

        // back-to-back start in the DONE cycle
        start_op(8'h20, 8'h0F, 1'b0);
        wait_done();
        a     = 8'h01;
        b     = 8'h01;
        modo  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        q.push_back(model(8'h01, 8'h01, 1'b0));
        tq.push_back($time);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_done", {31'd0, done}, 32'd0);
        check("s_held", {24'd0, s}, 32'h2F);
        wait_done();

        // reset on the 4th CALC edge
        start_op(8'h3C, 8'h05, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_s", {24'd0, s}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        void'(q.pop_back());
        void'(tq.pop_back());
        rst = 1'b0;
        repeat (12) @(negedge clk);
        start_op(8'h11, 8'h22, 1'b0);
        wait_done();

        repeat (2) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/somador_subtrator_serial.md
# somador_subtrator_serial

Bit-serial N-bit adder/subtractor for the adders/subtractors library. It adds or subtracts two latched operands one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop. A start/busy/done handshake frames each operation. It produces the sum, the raw carry-out and the signed overflow, and is the area-minimal alternative to the parallel ripple-carry adder.

## Interface
- N, default 8: operand and result width in bits; legal range N ≥ 2.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- modo  input  1  operation select: 0 means a+b, 1 means a−b (computed as a + ~b + 1). Latched with the operands.
- a  input  N  operand A; latched on the accepting edge.
- b  input  N  operand B; latched on the accepting edge.
- s  output  N  result; holds the previous result until the new one completes.
- c  output  1  carry-out of the MSB. In subtraction, 1 means no borrow.
- ovf  output  1  two's-complement overflow of the completed operation.
- busy  output  1  high while bits are being computed.
- done  output  1  single-cycle pulse marking a new valid s/c/ovf.

## Operation
- States:
  - IDLE: busy=0, done=0.
  - CALC: busy=1, bit counter cnt runs 0..N−1.
  - DONE: busy=0, done=1, lasts one cycle.
- IDLE with start=1: latch a, b and modo into internal shift registers, set the carry flip-flop to modo, set cnt=0, go to CALC.
- IDLE with start=0: remain in IDLE.
- Each CALC edge performs one bit step:
  - bit sum = a[0] ^ bb[0] ^ cy, where bb = b when modo=0 and ~b when modo=1.
  - The carry flip-flop takes the majority of (a[0], bb[0], cy).
  - Both operand registers shift right; the sum bit shifts into the internal result register at the MSB.
  - cnt increments.
- On the CALC edge with cnt=N−1:
  - Copy the internal result to s.
  - c ← final carry.
  - ovf ← carry into the MSB XOR carry out of the MSB.
  - Go to DONE.
- DONE with start=1: accept a new operation exactly as from IDLE (back-to-back operation, no idle gap).
- DONE with start=0: go to IDLE.
- start during CALC is ignored; it is neither queued nor able to alter the current operation.
- Changes on a, b or modo after the accepting edge have no effect on the running operation.
- s, c and ovf change only on the completing edge and are otherwise held indefinitely.

## Timing
- Reset: rst=1 at a rising edge forces IDLE and clears s, c, ovf, busy, done, cnt, the carry flip-flop and all internal registers. This holds in every state, including mid-CALC.
  - A mid-CALC reset discards the operation; no done pulse is produced for it.
  - rst has priority over start.
- Let the accepting edge be E0:
  - busy is 1 from after E0 through the edge E0+N.
  - The result is written and done=1 after edge E0+N, lasting exactly one cycle.
  - Latency is N clock cycles from the accepting edge to done.
- Back-to-back: if start=1 during the DONE cycle, busy rises on the following edge and done falls on that edge. Throughput is one result per N+1 cycles.
- Arithmetic is modulo 2^N for s. c is the (N+1)-th bit of a + bb + modo.

## Test plan
- Reset: hold rst for 2 cycles, with start=1 and random a/b. Required after the first edge: s=0, c=0, ovf=0, busy=0, done=0.
- Add, N=8, modo=0, a=8'h3C, b=8'h05:
  - s=8'h41, c=0, ovf=0.
  - busy high for 8 cycles; done pulses exactly 8 cycles after the accepting edge, for one cycle.
- Add boundaries:
  - 8'hFF+8'h01 gives s=8'h00, c=1, ovf=0.
  - 8'h7F+8'h01 gives s=8'h80, c=0, ovf=1.
- Subtract, modo=1:
  - 8'h05−8'h07 gives s=8'hFE, c=0, ovf=0.
  - 8'h80−8'h01 gives s=8'h7F, c=1, ovf=1.
  - 8'h10−8'h10 gives s=8'h00, c=1, ovf=0.
- Handshake:
  - Hold start=1 and change a to 8'hAA during CALC. Required: the result is from the latched operands and no extra start is accepted while busy.
  - Assert start in the DONE cycle with a=8'h01, b=8'h01, modo=0. Required: busy on the next edge and s=8'h02 after 8 more cycles.
- Reset mid-operation: assert rst on the 4th CALC edge of 8'h3C+8'h05. Required:
  - On the next edge: busy=0, s=0, and no done pulse.
  - A following 8'h11+8'h22 gives s=8'h33, c=0, ovf=0.
